// File: rtl/sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver
//   Time-multiplexed driver for an 8-digit common-anode seven-segment display.
//   Each digit gets a slot of SCAN_DIV cycles. The first BLANK_CYCLES of every
//   slot keep all anodes off so the previous digit's segments never ghost into
//   the next one. New values are captured into a shadow copy and only become
//   active at the frame boundary, so a frame is never shown half-updated.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   data       in   32  hex nibbles, digit i = data[4i+3:4i]
//   dp_in      in   8   decimal point request per digit, 1 = lit
//   en_mask    in   8   digit enable, 1 = digit shown
//   load       in   1   capture data/dp_in/en_mask into the shadow copy
//   pending    out  1   shadow holds values not yet displayed
//   frame_tick out  1   one-cycle pulse in the first cycle of each frame
//   an         out  8   anodes, active-low
//   seg        out  7   segments a..g on seg[0]..seg[6], active-low
//   dp         out  1   decimal point, active-low
// -----------------------------------------------------------------------------
module sevenseg_scan_driver #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en_mask,
    input  logic        load,
    output logic        pending,
    output logic        frame_tick,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned CntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] r_cnt;
    logic [2:0]      r_d;

    logic [31:0] r_act_data;
    logic [7:0]  r_act_dp;
    logic [7:0]  r_act_mask;
    logic [31:0] r_sh_data;
    logic [7:0]  r_sh_dp;
    logic [7:0]  r_sh_mask;
    logic        r_pending;

    logic        r_frame_tick;
    logic [7:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_dp;

    logic        w_slot_end;
    logic        w_boundary;
    logic        w_blank;
    logic        w_show;
    logic [3:0]  w_nib;
    logic [6:0]  w_hex;
    logic [7:0]  w_an_on;

    // Hex glyphs, bit order g..a, active-low.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // With no blank phase the comparison would be constant, so drop it.
    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign w_blank = 1'b0;
    end else begin : g_blank
        assign w_blank = 32'(r_cnt) < BLANK_CYCLES;
    end

    always_comb begin
        w_slot_end = (r_cnt == CntMax);
        w_boundary = w_slot_end && (r_d == 3'd7);
        w_nib      = r_act_data[{r_d, 2'b00} +: 4];
        w_hex      = hex_to_seg(w_nib);
        w_an_on    = ~(8'b1 << r_d);
        w_show     = !w_blank && r_act_mask[r_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_d          <= 3'd0;
            r_act_data   <= 32'h0;
            r_act_dp     <= 8'h00;
            r_act_mask   <= 8'h00;
            r_sh_data    <= 32'h0;
            r_sh_dp      <= 8'h00;
            r_sh_mask    <= 8'h00;
            r_pending    <= 1'b0;
            r_frame_tick <= 1'b0;
            r_an         <= 8'hFF;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
        end else begin
            // Registered so the pulse lands in the cycle where cnt=0, d=0.
            r_frame_tick <= w_boundary;

            if (w_slot_end) begin
                r_cnt <= '0;
                r_d   <= r_d + 3'd1;
            end else begin
                r_cnt <= r_cnt + CntW'(1);
            end

            if (w_show) begin
                r_an  <= w_an_on;
                r_seg <= w_hex;
                r_dp  <= ~r_act_dp[r_d];
            end else begin
                r_an  <= 8'hFF;
                r_seg <= 7'h7F;
                r_dp  <= 1'b1;
            end

            if (load) begin
                r_sh_data <= data;
                r_sh_dp   <= dp_in;
                r_sh_mask <= en_mask;
            end

            if (w_boundary) begin
                // A load on the boundary itself wins over the older shadow.
                r_pending <= 1'b0;
                if (load) begin
                    r_act_data <= data;
                    r_act_dp   <= dp_in;
                    r_act_mask <= en_mask;
                end else if (r_pending) begin
                    r_act_data <= r_sh_data;
                    r_act_dp   <= r_sh_dp;
                    r_act_mask <= r_sh_mask;
                end
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign pending    = r_pending;
    assign frame_tick = r_frame_tick;
    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_driver
//   Two instances (SCAN_DIV=8/BLANK=2 and SCAN_DIV=4/BLANK=0) share inputs.
//   A cycle-indexed model derives expected outputs from the frame position
//   (cycle count since reset) and is compared on every falling edge.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

    localparam int SD0 = 8;
    localparam int BL0 = 2;
    localparam int SD1 = 4;
    localparam int BL1 = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] data = 32'h0;
    logic [7:0]  dp_in = 8'h0;
    logic [7:0]  en_mask = 8'h0;

    logic       pending0, tick0, dp0, pending1, tick1, dp1;
    logic [7:0] an0, an1;
    logic [6:0] seg0, seg1;

    always #5 clk = ~clk;

    sevenseg_scan_driver #(.SCAN_DIV(SD0), .BLANK_CYCLES(BL0)) u_dut0 (
        .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .en_mask(en_mask),
        .load(load), .pending(pending0), .frame_tick(tick0), .an(an0), .seg(seg0),
        .dp(dp0)
    );

    sevenseg_scan_driver #(.SCAN_DIV(SD1), .BLANK_CYCLES(BL1)) u_dut1 (
        .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .en_mask(en_mask),
        .load(load), .pending(pending1), .frame_tick(tick1), .an(an1), .seg(seg1),
        .dp(dp1)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    int sdv [2] = '{SD0, SD1};
    int blv [2] = '{BL0, BL1};

    int          t [2];
    logic [31:0] m_data [2];
    logic [7:0]  m_dp [2];
    logic [7:0]  m_mask [2];
    logic [31:0] s_data [2];
    logic [7:0]  s_dp [2];
    logic [7:0]  s_mask [2];
    logic        m_pend [2];
    logic [7:0]  e_an [2];
    logic [6:0]  e_seg [2];
    logic        e_dp [2];
    logic        e_tick [2];
    bit          started = 1'b0;

    task automatic model_step(input int k);
        int pos, dig, c;
        logic [3:0] nib;
        if (rst) begin
            t[k] = 0;
            m_data[k] = '0; m_dp[k] = '0; m_mask[k] = '0;
            s_data[k] = '0; s_dp[k] = '0; s_mask[k] = '0;
            m_pend[k] = 1'b0;
            e_an[k] = 8'hFF; e_seg[k] = 7'h7F; e_dp[k] = 1'b1; e_tick[k] = 1'b0;
        end else begin
            pos = t[k] % (8 * sdv[k]);
            dig = pos / sdv[k];
            c   = pos % sdv[k];
            if (c >= blv[k] && m_mask[k][dig]) begin
                nib = m_data[k][4*dig +: 4];
                e_an[k] = 8'hFF;
                e_an[k][dig] = 1'b0;
                e_seg[k] = hex_tab[nib];
                e_dp[k] = ~m_dp[k][dig];
            end else begin
                e_an[k] = 8'hFF; e_seg[k] = 7'h7F; e_dp[k] = 1'b1;
            end
            e_tick[k] = (pos == 8 * sdv[k] - 1);
            if (pos == 8 * sdv[k] - 1) begin
                if (load) begin
                    m_data[k] = data; m_dp[k] = dp_in; m_mask[k] = en_mask;
                end else if (m_pend[k]) begin
                    m_data[k] = s_data[k]; m_dp[k] = s_dp[k]; m_mask[k] = s_mask[k];
                end
                m_pend[k] = 1'b0;
            end else if (load) begin
                s_data[k] = data; s_dp[k] = dp_in; s_mask[k] = en_mask;
                m_pend[k] = 1'b1;
            end
            t[k]++;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        started = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("an0", an0, e_an[0]);
            chk("seg0", seg0, e_seg[0]);
            chk("dp0", dp0, e_dp[0]);
            chk("pending0", pending0, m_pend[0]);
            chk("tick0", tick0, e_tick[0]);
            chk("an1", an1, e_an[1]);
            chk("seg1", seg1, e_seg[1]);
            chk("dp1", dp1, e_dp[1]);
            chk("pending1", pending1, m_pend[1]);
            chk("tick1", tick1, e_tick[1]);
            chk("an0_single", ($countones(~an0) <= 1), 1);
            chk("an1_single", ($countones(~an1) <= 1), 1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_t(input int n);
        int g = 0;
        while (t[0] != n && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (t[0] != n) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_t: at cycle %0d, wanted cycle %0d", t[0], n);
        end
    endtask

    task automatic wait_pos(input int p);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((t[0] % 64) != p && g < 1000);
        if ((t[0] % 64) != p) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_pos: at position %0d, wanted %0d", t[0] % 64, p);
        end
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] m);
        load = 1'b1; data = d; dp_in = p; en_mask = m;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt, nlit, fs, nbad_seg;

        // Reset and idle display.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_an", an0, 8'hFF);
        chk("rst_seg", seg0, 7'h7F);
        chk("rst_pending", pending0, 0);
        chk("rst_tick", tick0, 0);
        rst = 1'b0;
        nt = 0; nlit = 0;
        for (int i = 0; i < 192; i++) begin
            @(negedge clk);
            if (tick0) nt++;
            if (an0 !== 8'hFF) nlit++;
            if (t[0] == 64) chk("first_tick", tick0, 1);
            if (t[0] == 63) chk("no_early_tick", tick0, 0);
        end
        chk("idle_ticks", nt, 3);
        chk("idle_dark", nlit, 0);

        // Mid-frame load, then walk through the next frame.
        wait_pos(20);
        do_load(32'h76543210, 8'h01, 8'hFF);
        @(negedge clk);
        load = 1'b0;
        chk("pending_after_load", pending0, 1);
        wait_t(259);
        chk("d0_an", an0, 8'hFE);
        chk("d0_seg", seg0, 7'b1000000);
        chk("d0_dp", dp0, 0);
        chk("d0_pending", pending0, 0);
        wait_t(265);
        chk("d1_blank_an", an0, 8'hFF);
        wait_t(268);
        chk("d1_an", an0, 8'hFD);
        chk("d1_seg", seg0, 7'b1111001);
        chk("d1_dp", dp0, 1);
        wait_t(320);
        chk("d7_an", an0, 8'h7F);
        chk("d7_seg", seg0, 7'b1111000);
        wait_t(321);
        chk("wrap_blank_an", an0, 8'hFF);

        // Masked upper digits.
        wait_pos(10);
        do_load(32'hFFFFFFFF, 8'h00, 8'h0F);
        @(negedge clk);
        load = 1'b0;
        fs = (t[0] / 64 + 1) * 64;
        wait_t(fs + 1);
        nlit = 0; nbad_seg = 0;
        for (int i = 0; i < 64; i++) begin
            if (an0[7:4] !== 4'hF) nlit++;
            if (an0[3:0] !== 4'hF && seg0 !== 7'b0001110) nbad_seg++;
            @(negedge clk);
        end
        chk("mask_upper_dark", nlit, 0);
        chk("mask_lower_F", nbad_seg, 0);

        // Last load before the boundary wins.
        wait_pos(5);
        do_load(32'h11111111, 8'h00, 8'hFF);
        @(negedge clk);
        do_load(32'h22222222, 8'h00, 8'hFF);
        @(negedge clk);
        load = 1'b0;
        fs = (t[0] / 64 + 1) * 64;
        wait_t(fs + 3);
        chk("last_load_seg", seg0, 7'b0100100);

        // Load on the boundary itself overrides an older pending shadow.
        wait_pos(40);
        do_load(32'h33333333, 8'h00, 8'hFF);
        @(negedge clk);
        load = 1'b0;
        wait_pos(63);
        do_load(32'hAAAAAAAA, 8'h00, 8'hFF);
        @(negedge clk);
        load = 1'b0;
        chk("bnd_pending", pending0, 0);
        wait_pos(3);
        chk("bnd_seg", seg0, 7'b0001000);
        chk("bnd_pending2", pending0, 0);

        // Reset during digit 3's ON phase with a pending load.
        wait_pos(10);
        do_load(32'h55555555, 8'hFF, 8'hFF);
        @(negedge clk);
        load = 1'b0;
        wait_pos(29);
        chk("pre_rst_pending", pending0, 1);
        chk("pre_rst_an", an0, 8'hF7);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_an", an0, 8'hFF);
        chk("mid_rst_pending", pending0, 0);
        rst = 1'b0;
        nt = 0; nlit = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (t[0] < 64 && tick0) nt++;
            if (an0 !== 8'hFF) nlit++;
        end
        chk("post_rst_tick", tick0, 1);
        chk("post_rst_no_early", nt, 0);
        chk("post_rst_dark", nlit, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            load = ($urandom_range(0, 24) == 0);
            data = $urandom;
            dp_in = 8'($urandom);
            en_mask = 8'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        load = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
